mm_core: RTL and testbench
==========================

MM_CORE -- requirements
Module: mm_core

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width; matches the 256-word shared data memory.
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 Parameter DIM_W, default 4, width of dimension and row-index inputs.
REQ-004 Port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, one-cycle request to begin a job; sampled only in IDLE.
REQ-007 Ports dim_m / dim_n / dim_p, input, DIM_W each, A is MxN, B is NxP, C is MxP.
REQ-008 Ports base_a / base_b / base_c, input, ADDR_W each, word base addresses of row-major A, B, C.
REQ-009 Ports row_first / row_stride, input, DIM_W each, first C row computed and row increment (multi-core partitioning).
REQ-010 Port mem_addr, output, ADDR_W, address to one data-memory port.
REQ-011 Port mem_write_en, output, 1, write strobe to that port.
REQ-012 Port mem_datain, output, DATA_W, write data to that port.
REQ-013 Port mem_dataout, input, DATA_W, registered read data: the word at the mem_addr of the previous cycle, valid only when mem_write_en was 0.
REQ-014 Port busy, output, 1, high while a job runs.
REQ-015 Port done, output, 1, one-cycle completion pulse.

Function
REQ-016 All inputs in REQ-007..REQ-009 shall be latched when start is accepted; later changes are ignored until the next job.
REQ-017 FSM states: IDLE, FETCH_A, FETCH_B, MAC, WRITE, DONE.
REQ-018 IDLE + start: if any dim is 0 or row_first >= dim_m, go to DONE with no memory access; otherwise go to FETCH_A with i=row_first, j=0, k=0, acc=0.
REQ-019 FETCH_A: mem_addr = base_a + i*N + k, mem_write_en=0; next FETCH_B.
REQ-020 FETCH_B: mem_addr = base_b + k*P + j, mem_write_en=0; A word (present on mem_dataout) is captured; next MAC.
REQ-021 MAC: acc <= acc + a_word*mem_dataout; if k<N-1 then k++ and go to FETCH_A, else go to WRITE.
REQ-022 WRITE: mem_addr = base_c + i*P + j, mem_write_en=1 for exactly this cycle, mem_datain=acc; then acc=0, k=0; if j<P-1 then j++, else j=0 and i += max(row_stride,1); go to DONE if new i >= M, else FETCH_A.
REQ-023 DONE: done=1 for one cycle, busy=0; next IDLE.
REQ-024 Arithmetic unsigned; product and accumulator truncated to DATA_W bits (mod 2^16); address arithmetic wraps mod 2^ADDR_W.
REQ-025 busy=1 in FETCH_A, FETCH_B, MAC, WRITE; job length = (3N+1)*P*rows cycles, rows = number of i values visited.
REQ-026 start while not in IDLE shall be ignored.
REQ-027 mem_write_en shall never be 1 outside WRITE.

Reset
REQ-028 reset shall force IDLE, mem_addr=0, mem_write_en=0, mem_datain=0, busy=0, done=0, acc=0, counters 0, on the next edge, from any state.
REQ-029 reset mid-job shall abandon the job with no further writes; a following start shall run a full fresh job.

Structure
REQ-030 Shared package mm_pkg holds ADDR_W, DATA_W, DIM_W defaults and the FSM state encoding.
REQ-031 One sub-module mm_addr_gen shall compute the A, B, C addresses combinationally from bases, dims, i, j, k.

Verification
REQ-032 A=[[1,2],[3,4]]@0x00, B=[[5,6],[7,8]]@0x10, base_c=0x20, M=N=P=2, row_first=0, stride=1 -> writes 19,22,43,50 to 0x20..0x23, busy high 28 cycles, done pulse next cycle.
REQ-033 N=2, A row=[0x00FF,1], B col=[0x0101,1] -> C word 0x0000 (wrap).
REQ-034 M=4, row_first=1, stride=2 -> only C rows 1 and 3 written; rows 0 and 2 untouched.
REQ-035 dim_n=0 with start -> done pulses the cycle after next, mem_write_en never asserted, busy stays 0.
REQ-036 reset asserted during MAC of first element -> next cycle all outputs 0, no write; re-run of REQ-032 yields the same results.
REQ-037 start pulsed again mid-job -> ignored; exactly one done pulse and M*P writes.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply core: default widths and the
// controller state encoding.
package mm_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DIM_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    MAC     = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5
  } mm_state_t;

  // True for the states in which a job is in progress.
  function automatic logic state_is_busy(input mm_state_t st);
    state_is_busy = (st == FETCH_A) || (st == FETCH_B) ||
                    (st == MAC)     || (st == WRITE);
  endfunction

endpackage

// File: rtl/mm_addr_gen.sv
// Word-address generator for row-major A, B and C. Pure combinational;
// every sum wraps at ADDR_W bits.
module mm_addr_gen import mm_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_p,
  input  logic [DIM_W-1:0]  row_i,
  input  logic [DIM_W-1:0]  col_j,
  input  logic [DIM_W-1:0]  idx_k,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c
);

  logic [2*DIM_W-1:0] off_a_s;
  logic [2*DIM_W-1:0] off_b_s;
  logic [2*DIM_W-1:0] off_c_s;

  // Row offsets (i*N, k*P, i*P) and the three final addresses.
  always_comb begin
    off_a_s = {{DIM_W{1'b0}}, row_i} * {{DIM_W{1'b0}}, dim_n};
    off_b_s = {{DIM_W{1'b0}}, idx_k} * {{DIM_W{1'b0}}, dim_p};
    off_c_s = {{DIM_W{1'b0}}, row_i} * {{DIM_W{1'b0}}, dim_p};
    addr_a  = base_a + ADDR_W'(off_a_s) + ADDR_W'(idx_k);
    addr_b  = base_b + ADDR_W'(off_b_s) + ADDR_W'(col_j);
    addr_c  = base_c + ADDR_W'(off_c_s) + ADDR_W'(col_j);
  end

endmodule

// File: rtl/mm_core.sv
// Matrix-multiply core: C = A x B over a single registered-read memory port.
// Each C element costs N x (FETCH_A, FETCH_B, MAC) plus one WRITE cycle.
// All memory-port and status outputs are registered; their next values are
// derived from the next state and next counters so they line up with the
// state they belong to.
module mm_core import mm_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_p,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [DIM_W-1:0]  row_first,
  input  logic [DIM_W-1:0]  row_stride,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy,
  output logic              done
);

  mm_state_t         state_r, state_s;
  logic              accept_s;

  // Job configuration captured when start is accepted.
  logic [DIM_W-1:0]  dim_m_r, dim_n_r, dim_p_r, stride_r;
  logic [ADDR_W-1:0] base_a_r, base_b_r, base_c_r;

  // Configuration seen by the address generator (live inputs on the accept cycle).
  logic [DIM_W-1:0]  dim_n_s, dim_p_s;
  logic [ADDR_W-1:0] base_a_s, base_b_s, base_c_s;

  logic [DIM_W-1:0]  i_r, j_r, k_r, i_s, j_s, k_s;
  logic [DATA_W-1:0] acc_r, acc_s, a_word_r, a_word_s;

  logic [DIM_W:0]    k_inc_s, j_inc_s, i_adv_s;
  logic [DIM_W-1:0]  step_s;

  logic [ADDR_W-1:0] addr_a_s, addr_b_s, addr_c_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              mem_write_en_s;
  logic [DATA_W-1:0] mem_datain_s;

  // Loop-bound helpers, one bit wider so the compare never wraps.
  always_comb begin
    k_inc_s = {1'b0, k_r} + (DIM_W+1)'(1'b1);
    j_inc_s = {1'b0, j_r} + (DIM_W+1)'(1'b1);
    if (stride_r == {DIM_W{1'b0}}) begin
      step_s = DIM_W'(1'b1);
    end else begin
      step_s = stride_r;
    end
    i_adv_s = {1'b0, i_r} + {1'b0, step_s};
  end

  // Next-state logic and datapath updates for counters, A word and accumulator.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    i_s      = i_r;
    j_s      = j_r;
    k_s      = k_r;
    acc_s    = acc_r;
    a_word_s = a_word_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if ((dim_m == {DIM_W{1'b0}}) || (dim_n == {DIM_W{1'b0}}) ||
              (dim_p == {DIM_W{1'b0}}) || (row_first >= dim_m)) begin
            state_s = DONE;
          end else begin
            state_s = FETCH_A;
            i_s     = row_first;
            j_s     = {DIM_W{1'b0}};
            k_s     = {DIM_W{1'b0}};
            acc_s   = {DATA_W{1'b0}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH_A: state_s = FETCH_B;
      FETCH_B: begin
        a_word_s = mem_dataout;
        state_s  = MAC;
      end
      MAC: begin
        acc_s = acc_r + a_word_r * mem_dataout;
        if (k_inc_s < {1'b0, dim_n_r}) begin
          k_s     = k_inc_s[DIM_W-1:0];
          state_s = FETCH_A;
        end else begin
          state_s = WRITE;
        end
      end
      WRITE: begin
        acc_s = {DATA_W{1'b0}};
        k_s   = {DIM_W{1'b0}};
        if (j_inc_s < {1'b0, dim_p_r}) begin
          j_s     = j_inc_s[DIM_W-1:0];
          state_s = FETCH_A;
        end else begin
          j_s = {DIM_W{1'b0}};
          i_s = i_adv_s[DIM_W-1:0];
          if (i_adv_s >= {1'b0, dim_m_r}) begin
            state_s = DONE;
          end else begin
            state_s = FETCH_A;
          end
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Address-generator configuration: live inputs while a start is being accepted.
  always_comb begin
    if (accept_s) begin
      dim_n_s  = dim_n;
      dim_p_s  = dim_p;
      base_a_s = base_a;
      base_b_s = base_b;
      base_c_s = base_c;
    end else begin
      dim_n_s  = dim_n_r;
      dim_p_s  = dim_p_r;
      base_a_s = base_a_r;
      base_b_s = base_b_r;
      base_c_s = base_c_r;
    end
  end

  mm_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .base_a (base_a_s),
    .base_b (base_b_s),
    .base_c (base_c_s),
    .dim_n  (dim_n_s),
    .dim_p  (dim_p_s),
    .row_i  (i_s),
    .col_j  (j_s),
    .idx_k  (k_s),
    .addr_a (addr_a_s),
    .addr_b (addr_b_s),
    .addr_c (addr_c_s)
  );

  // Next memory-port values for the state about to be entered.
  always_comb begin
    mem_addr_s     = {ADDR_W{1'b0}};
    mem_write_en_s = 1'b0;
    mem_datain_s   = {DATA_W{1'b0}};
    case (state_s)
      FETCH_A: mem_addr_s = addr_a_s;
      FETCH_B: mem_addr_s = addr_b_s;
      WRITE: begin
        mem_addr_s     = addr_c_s;
        mem_write_en_s = 1'b1;
        mem_datain_s   = acc_s;
      end
      default: mem_addr_s = {ADDR_W{1'b0}};
    endcase
  end

  // State, configuration, datapath and registered-output update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      dim_m_r      <= {DIM_W{1'b0}};
      dim_n_r      <= {DIM_W{1'b0}};
      dim_p_r      <= {DIM_W{1'b0}};
      stride_r     <= {DIM_W{1'b0}};
      base_a_r     <= {ADDR_W{1'b0}};
      base_b_r     <= {ADDR_W{1'b0}};
      base_c_r     <= {ADDR_W{1'b0}};
      i_r          <= {DIM_W{1'b0}};
      j_r          <= {DIM_W{1'b0}};
      k_r          <= {DIM_W{1'b0}};
      acc_r        <= {DATA_W{1'b0}};
      a_word_r     <= {DATA_W{1'b0}};
      mem_addr     <= {ADDR_W{1'b0}};
      mem_write_en <= 1'b0;
      mem_datain   <= {DATA_W{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        dim_m_r  <= dim_m;
        dim_n_r  <= dim_n;
        dim_p_r  <= dim_p;
        stride_r <= row_stride;
        base_a_r <= base_a;
        base_b_r <= base_b;
        base_c_r <= base_c;
      end
      i_r          <= i_s;
      j_r          <= j_s;
      k_r          <= k_s;
      acc_r        <= acc_s;
      a_word_r     <= a_word_s;
      mem_addr     <= mem_addr_s;
      mem_write_en <= mem_write_en_s;
      mem_datain   <= mem_datain_s;
      busy         <= state_is_busy(state_s);
      done         <= (state_s == DONE);
    end
  end

endmodule

// File: tb/tb_mm_core.sv
// Self-checking bench for mm_core: a behavioural data memory, a reference
// matrix-multiply model feeding a queue of expected C writes, and a negedge
// monitor that pops and compares every write the core issues.
module tb_mm_core;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  dim_m, dim_n, dim_p, row_first, row_stride;
  logic [7:0]  base_a, base_b, base_c;
  logic [7:0]  mem_addr;
  logic        mem_write_en;
  logic [15:0] mem_datain;
  logic [15:0] mem_dataout;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem [0:255];
  logic [15:0] rd_q;
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [15:0] tb_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int last_busy = 0;
  int done_cyc = 0;

  mm_core #(.ADDR_W(8), .DATA_W(16), .DIM_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .dim_m        (dim_m),
    .dim_n        (dim_n),
    .dim_p        (dim_p),
    .base_a       (base_a),
    .base_b       (base_b),
    .base_c       (base_c),
    .row_first    (row_first),
    .row_stride   (row_stride),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory with registered read; bench preload uses the same port.
  always @(posedge clock) begin
    if (mem_write_en) begin
      mem[mem_addr] <= mem_datain;
    end else begin
      rd_q <= mem[mem_addr];
      if (tb_we) mem[tb_addr] <= tb_data;
    end
  end
  assign mem_dataout = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: activity counters and scoreboard compare for every write.
  always @(negedge clock) begin
    wr_t e;
    cyc++;
    if (busy === 1'b1) begin
      busy_cnt++;
      last_busy = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_write_en === 1'b1) begin
      wr_cnt++;
      check("we_while_busy", {31'd0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", {16'd0, mem_datain}, {16'd0, e.data});
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(posedge clock); #1;
    tb_we = 1'b0;
  endtask

  // Reference model: pushes the expected C writes in issue order.
  task automatic push_expected(input int dm, input int dn, input int dp,
                               input logic [7:0] ba, input logic [7:0] bb,
                               input logic [7:0] bc, input int rf, input int rs,
                               output int rows);
    int step;
    logic [7:0]  aa, ab;
    logic [15:0] acc;
    wr_t w;
    rows = 0;
    if (dm == 0 || dn == 0 || dp == 0 || rf >= dm) return;
    step = (rs == 0) ? 1 : rs;
    for (int i = rf; i < dm; i += step) begin
      rows++;
      for (int j = 0; j < dp; j++) begin
        acc = 16'd0;
        for (int k = 0; k < dn; k++) begin
          aa  = 8'(int'(ba) + i*dn + k);
          ab  = 8'(int'(bb) + k*dp + j);
          acc = acc + mem[aa] * mem[ab];
        end
        w.addr = 8'(int'(bc) + i*dp + j);
        w.data = acc;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic drive_cfg(input int dm, input int dn, input int dp,
                           input logic [7:0] ba, input logic [7:0] bb,
                           input logic [7:0] bc, input int rf, input int rs);
    dim_m = 4'(dm); dim_n = 4'(dn); dim_p = 4'(dp);
    base_a = ba; base_b = bb; base_c = bc;
    row_first = 4'(rf); row_stride = 4'(rs);
  endtask

  // One complete job: model, start pulse, bounded wait, then timing checks.
  task automatic run_job(input string tag, input int dm, input int dn, input int dp,
                         input logic [7:0] ba, input logic [7:0] bb,
                         input logic [7:0] bc, input int rf, input int rs,
                         input bit mid_start);
    int rows, b0, d0, w0, c0, budget, exp_len;
    push_expected(dm, dn, dp, ba, bb, bc, rf, rs, rows);
    exp_len = (3*dn + 1) * dp * rows;
    drive_cfg(dm, dn, dp, ba, bb, bc, rf, rs);
    b0 = busy_cnt; d0 = done_cnt; w0 = wr_cnt;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    c0 = cyc;
    budget = 0;
    while (done_cnt == d0 && budget < 2000) begin
      @(posedge clock); #1;
      budget++;
      if (mid_start && budget == 8) begin
        start = 1'b1;
        dim_m = 4'd1; dim_p = 4'd1; base_c = 8'hF0;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_no_timeout"}, {31'd0, budget < 2000}, 32'd1);
    repeat (4) begin
      @(posedge clock); #1;
    end
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(exp_len));
    check({tag, "_write_count"}, 32'(wr_cnt - w0), 32'(rows * dp));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    if (rows > 0) begin
      check({tag, "_done_after_busy"}, 32'(done_cyc - last_busy), 32'd1);
    end else begin
      check({tag, "_done_soon"}, {31'd0, (done_cyc - c0) <= 2}, 32'd1);
    end
  endtask

  task automatic load_032();
    poke(8'h00, 16'd1); poke(8'h01, 16'd2); poke(8'h02, 16'd3); poke(8'h03, 16'd4);
    poke(8'h10, 16'd5); poke(8'h11, 16'd6); poke(8'h12, 16'd7); poke(8'h13, 16'd8);
    for (int a = 32; a < 36; a++) poke(8'(a), 16'd0);
  endtask

  task automatic check_c032(input string tag);
    check({tag, "_c00"}, {16'd0, mem[8'h20]}, 32'd19);
    check({tag, "_c01"}, {16'd0, mem[8'h21]}, 32'd22);
    check({tag, "_c10"}, {16'd0, mem[8'h22]}, 32'd43);
    check({tag, "_c11"}, {16'd0, mem[8'h23]}, 32'd50);
  endtask

  initial begin
    int w0, b0;
    reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_addr = 8'd0; tb_data = 16'd0;
    drive_cfg(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_we", {31'd0, mem_write_en}, 32'd0);
    check("rst_datain", {16'd0, mem_datain}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 2x2 reference product.
    load_032();
    run_job("basic", 2, 2, 2, 8'h00, 8'h10, 8'h20, 0, 1, 1'b0);
    check_c032("basic");

    // Product and accumulator wrap at 16 bits.
    poke(8'h30, 16'h00FF); poke(8'h31, 16'h0001);
    poke(8'h40, 16'h0101); poke(8'h41, 16'h0001);
    poke(8'h50, 16'h1234);
    run_job("wrap", 1, 2, 1, 8'h30, 8'h40, 8'h50, 0, 1, 1'b0);
    check("wrap_c", {16'd0, mem[8'h50]}, 32'd0);

    // Row partitioning: rows 1 and 3 only.
    for (int a = 0; a < 8; a++) poke(8'(8'h70 + a), 16'(a*3 + 1));
    for (int a = 0; a < 4; a++) poke(8'(8'h80 + a), 16'(a + 2));
    for (int a = 0; a < 8; a++) poke(8'(8'h60 + a), 16'hDEAD);
    run_job("stride", 4, 2, 2, 8'h70, 8'h80, 8'h60, 1, 2, 1'b0);
    check("stride_row0_a", {16'd0, mem[8'h60]}, 32'hDEAD);
    check("stride_row0_b", {16'd0, mem[8'h61]}, 32'hDEAD);
    check("stride_row2_a", {16'd0, mem[8'h64]}, 32'hDEAD);
    check("stride_row2_b", {16'd0, mem[8'h65]}, 32'hDEAD);

    // Degenerate job: N = 0.
    run_job("zero_n", 2, 0, 2, 8'h00, 8'h10, 8'h20, 0, 1, 1'b0);

    // Reset while the first MAC is in progress.
    load_032();
    w0 = wr_cnt;
    drive_cfg(2, 2, 2, 8'h00, 8'h10, 8'h20, 0, 1);
    start = 1'b1;
    @(posedge clock); #1;            // FETCH_A
    start = 1'b0;
    @(posedge clock); #1;            // FETCH_B
    @(posedge clock); #1;            // MAC
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("abort_addr", {24'd0, mem_addr}, 32'd0);
    check("abort_we", {31'd0, mem_write_en}, 32'd0);
    check("abort_datain", {16'd0, mem_datain}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    b0 = busy_cnt;
    repeat (6) @(posedge clock);
    #1;
    check("abort_idle", 32'(busy_cnt - b0), 32'd0);
    check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    load_032();
    run_job("rerun", 2, 2, 2, 8'h00, 8'h10, 8'h20, 0, 1, 1'b0);
    check_c032("rerun");

    // Second start mid-job (with altered inputs) is ignored.
    load_032();
    run_job("restart", 2, 2, 2, 8'h00, 8'h10, 8'h20, 0, 1, 1'b1);
    check_c032("restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
